mul_add: RTL and testbench
==========================

// Module: mul_add
// PURPOSE
//  Multiply-accumulate step for an FIR/dot-product chain: registers a*x on the clock edge, then adds an incoming partial sum.
//  res = reg(ai*xni) + resprev, all unsigned. Built from two sub-modules: mul (registered multiplier) and addr (combinational adder).
//  Instances are chained: one stage's res (low bits) feeds the next stage's resprev.
// PARAMETERS
//  SZin  8  MSB index of the operand ports; operand width W = SZin+1; product width P = 2*W; sum width P+1
// PORTS
//  clk      in   1      single clock; product register updates on rising edge
//  rst      in   1      reset; asynchronous, active-high
//  ai       in   W      coefficient, unsigned
//  xni      in   W      sample, unsigned
//  resprev  in   P      partial sum from the previous stage, unsigned
//  res      out  P+1    registered product + resprev, unsigned, full carry kept
// BEHAVIOUR
//  - Reset: rst=1 clears the product register to 0 immediately, with no clock edge needed; res then equals {1'b0,resprev}.
//  - Clocked path: on each rising clk with rst=0, prod <= ai*xni, computed exactly over P bits (no truncation possible).
//  - Latency: one cycle from ai/xni to res. Operands must be stable before the rising edge; drive them on the falling edge.
//  - Combinational path: res = prod + resprev, zero-extended to P+1 bits.
//    - The carry-out is the MSB of res. No overflow or saturation; max = (2^W-1)^2 + 2^P-1 fits in P+1 bits.
//    - resprev changes reach res in the same cycle, with no register on that path.
//  - Boundaries:
//    - ai=0 or xni=0 gives prod=0.
//    - All-ones operands give prod=2^P-2^(W+1)+1.
//    - A reset asserted mid-stream discards the pending product. The first valid product appears one rising edge after rst deasserts.
//    - rst held high together with a clock edge keeps prod=0.
//  - No handshake and no valid signal; a new result is produced every cycle.
// STRUCTURE
//  - No shared package needed. The only derived constants are W=SZin+1 and P=2*W, as localparams.
//  - Sub-module mul #(LENin1,LENin2): ports clk, rst, in1, in2, res.
//    - Generate-built unsigned partial-product array (shifted AND rows summed).
//    - Result width LENin1+LENin2, held in an async-reset output register.
//  - Sub-module addr #(SZin): ports in1, in2 [SZin:0]; output res [SZin+1:0].
//    - Generate-built ripple-carry chain of full adders, purely combinational.
//  - Top mul_add instantiates mul (LENin1 = LENin2 = W) and addr (SZin = P-1).
// TESTING (bench with SZin=3: W=4, P=8, res 9 bits; change inputs on negedge)
//  1. rst=1, ai=7, xni=9, resprev=20, clocks running -> res=20 throughout.
//     Drop rst; after the next rising edge -> res=83.
//  2. ai=15, xni=15, resprev=255 -> after the edge res=480 (carry bit set). Then ai=0 -> next edge res=255.
//  3. Hold ai=3, xni=5, change resprev 0->100 between edges -> res goes 15->115 with no clock edge.
//  4. Accumulate loop, resprev=res[7:0] each cycle, pairs (2,3),(4,5),(1,1):
//     res=6, then 26, then 27.
//  5. Assert rst asynchronously mid-cycle with prod=225 and resprev=0 -> res drops to 0 immediately.
//  6. 20 cycles of random ai/xni/resprev -> res equals the previous-edge ai*xni + current resprev on every cycle, checked by a reference model.

Source files
------------

// File: rtl/addr.sv
// Combinational unsigned ripple-carry adder; carry-out kept as the result MSB.
module addr #(
  parameter int SZin = 15
) (
  input  logic [SZin:0]   in1,
  input  logic [SZin:0]   in2,
  output logic [SZin+1:0] res
);

  // One full adder per bit; each stage takes its carry from the stage below.
  for (genvar i = 0; i <= SZin; i++) begin : g_fa
    logic ci;
    logic co;

    if (i == 0) begin : g_lsb
      assign ci = 1'b0;
    end else begin : g_chain
      assign ci = g_fa[i-1].co;
    end

    assign res[i] = in1[i] ^ in2[i] ^ ci;
    assign co     = (in1[i] & in2[i]) | (ci & (in1[i] ^ in2[i]));
  end

  assign res[SZin+1] = g_fa[SZin].co;

endmodule

// File: rtl/mul.sv
// Registered unsigned multiplier: shifted-AND partial-product rows summed
// combinationally, result captured in an async-reset output register.
module mul #(
  parameter int LENin1 = 9,
  parameter int LENin2 = 9
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [LENin1-1:0]          in1,
  input  logic [LENin2-1:0]          in2,
  output logic [LENin1+LENin2-1:0]   res
);

  localparam int PW = LENin1 + LENin2;

  logic [LENin2-1:0][PW-1:0] rows;
  logic [PW-1:0]             prod_d;
  logic [PW-1:0]             prod_q;

  // Row i is in1 shifted left by i, gated by bit i of in2.
  for (genvar i = 0; i < LENin2; i++) begin : g_row
    assign rows[i] = in2[i] ? (PW'(in1) << i) : '0;
  end

  // Sum all partial-product rows into the full-width product.
  always_comb begin
    // NOTE: assign a default before the loop so every path drives prod_d; otherwise a latch is inferred.
    prod_d = '0;
    for (int i = 0; i < LENin2; i++) begin
      // NOTE: blocking '=' here because each iteration builds on the previous partial sum within the same evaluation.
      prod_d = prod_d + rows[i];
    end
  end

  // Capture the product; an asserted reset clears it without waiting for a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_q <= '0;
    end else begin
      // NOTE: non-blocking '<=' for state so all registers update together at the edge.
      prod_q <= prod_d;
    end
  end

  assign res = prod_q;

endmodule

// File: rtl/mul_add.sv
// Multiply-accumulate stage: res = registered(ai*xni) + resprev, unsigned,
// full carry kept. Stages chain through res (low P bits) into resprev.
module mul_add #(
  parameter int SZin = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SZin:0]         ai,
  input  logic [SZin:0]         xni,
  input  logic [2*(SZin+1)-1:0] resprev,
  output logic [2*(SZin+1):0]   res
);

  localparam int W = SZin + 1;
  localparam int P = 2 * W;

  logic [P-1:0] prod;

  mul #(
    .LENin1 (W),
    .LENin2 (W)
  ) u_mul (
    .clk (clk),
    .rst (rst),
    .in1 (ai),
    .in2 (xni),
    .res (prod)
  );

  // The partial sum passes straight through the adder with no register.
  addr #(
    .SZin (P - 1)
  ) u_addr (
    .in1 (prod),
    .in2 (resprev),
    .res (res)
  );

endmodule

// File: tb/tb_mul_add.sv
// Self-checking bench for mul_add with SZin=3 (W=4, P=8, res 9 bits).
// Products are queued when operands are driven and retired after the edge.
module tb_mul_add;

  logic       clk;
  logic       rst;
  logic [3:0] ai;
  logic [3:0] xni;
  logic [7:0] resprev;
  logic [8:0] res;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_q[$];
  logic [7:0] prod_m;

  mul_add #(.SZin(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .ai      (ai),
    .xni     (xni),
    .resprev (resprev),
    .res     (res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [8:0] got, input logic [8:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  function automatic logic [8:0] model_res();
    return 9'(prod_m) + 9'(resprev);
  endfunction

  // Drive operands on the falling edge, queue the expected product,
  // then retire it after the rising edge and compare against the model.
  task automatic cycle(input string tag, input logic [3:0] a, input logic [3:0] x,
                       input logic [7:0] rp, input logic r);
    logic [7:0] p;
    @(negedge clk);
    ai      = a;
    xni     = x;
    resprev = rp;
    rst     = r;
    exp_q.push_back(8'(a) * 8'(x));
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 9'd1, 9'd0);
      p = '0;
    end else begin
      p = exp_q.pop_front();
    end
    prod_m = rst ? 8'd0 : p;
    check(tag, res, model_res());
  endtask

  initial begin
    logic [7:0] acc;
    rst     = 1'b1;
    ai      = 4'd7;
    xni     = 4'd9;
    resprev = 8'd20;
    prod_m  = '0;

    // 1. reset holds product at zero, clocks running
    #1;
    check("rst_async", res, 9'd20);
    cycle("rst_hold0", 4'd7, 4'd9, 8'd20, 1'b1);
    check("rst_hold0_const", res, 9'd20);
    cycle("rst_hold1", 4'd7, 4'd9, 8'd20, 1'b1);
    cycle("rst_release", 4'd7, 4'd9, 8'd20, 1'b0);
    check("first_prod_const", res, 9'd83);

    // 2. all-ones operands carry into the MSB; zero operand clears product
    cycle("all_ones", 4'd15, 4'd15, 8'd255, 1'b0);
    check("all_ones_const", res, 9'd480);
    cycle("ai_zero", 4'd0, 4'd15, 8'd255, 1'b0);
    check("ai_zero_const", res, 9'd255);
    cycle("xni_zero", 4'd9, 4'd0, 8'd7, 1'b0);

    // 3. resprev reaches res without a clock edge
    cycle("comb_base", 4'd3, 4'd5, 8'd0, 1'b0);
    check("comb_base_const", res, 9'd15);
    #1 resprev = 8'd100;
    #1 check("comb_resprev", res, 9'd115);
    check("comb_resprev_model", res, model_res());

    // 4. accumulate loop feeding res back as resprev
    cycle("acc0", 4'd2, 4'd3, 8'd0, 1'b0);
    check("acc0_const", res, 9'd6);
    acc = res[7:0];
    cycle("acc1", 4'd4, 4'd5, acc, 1'b0);
    check("acc1_const", res, 9'd26);
    acc = res[7:0];
    cycle("acc2", 4'd1, 4'd1, acc, 1'b0);
    check("acc2_const", res, 9'd27);

    // 5. asynchronous reset mid-cycle discards the product
    cycle("pre_rst", 4'd15, 4'd15, 8'd0, 1'b0);
    check("pre_rst_const", res, 9'd225);
    #2 rst = 1'b1;
    #1;
    prod_m = '0;
    check("mid_rst", res, 9'd0);
    cycle("rst_edge", 4'd5, 4'd5, 8'd0, 1'b1);
    check("rst_edge_const", res, 9'd0);
    cycle("post_rst", 4'd5, 4'd5, 8'd0, 1'b0);
    check("post_rst_const", res, 9'd25);

    // 6. random traffic against the reference model
    for (int i = 0; i < 20; i++) begin
      cycle($sformatf("rand%0d", i), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            8'($urandom_range(0, 255)), 1'b0);
    end

    check("queue_drained", 9'(exp_q.size()), 9'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
